// File: rtl/dvp_pattern_generator_if.sv
// DVP output bus plus the decoded pixel stream that accompanies it.
interface dvp_pattern_generator_if;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic        pixel_valid;
  logic [15:0] pixel_data;

  modport master (
    output dvp_vsync,
    output dvp_href,
    output dvp_data,
    output pixel_valid,
    output pixel_data
  );

  modport slave (
    input dvp_vsync,
    input dvp_href,
    input dvp_data,
    input pixel_valid,
    input pixel_data
  );
endinterface

// File: rtl/dvp_pattern_generator.sv
// RGB565 test-pattern source with camera-style DVP framing (VSYNC, HREF, byte-serial data).
// Every line type is LineLen clocks long; the FSM walks VSYNC -> VBACK -> ACTIVE -> VFRONT.
module dvp_pattern_generator #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic                          pattern_clk,
  input  logic                          pattern_reset_n,
  input  logic                          pattern_generator_enable,
  input  logic [1:0]                    pattern_selector,
  input  logic                          continuous_mode,
  input  logic                          start,
  dvp_pattern_generator_if.master       dvp,
  output logic                          busy,
  output logic                          frame_rdy,
  output logic [7:0]                    frame_count
);

  localparam int unsigned LineLen = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned ByteW   = $clog2(LineLen);
  localparam int unsigned LineW   = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  state_e             state_q, state_d;
  logic [ByteW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [LineW-1:0]   line_cnt_q, line_cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               vsync_q, vsync_d;
  logic               href_q, href_d;
  logic [7:0]         data_q, data_d;
  logic               pvalid_q, pvalid_d;
  logic [15:0]        pdata_q, pdata_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;
  logic [7:0]         fcnt_q, fcnt_d;

  int unsigned        state_lines;
  logic               byte_last, line_last, href_cur, y_bit3;
  logic [7:0]         x;
  logic [15:0]        pix;

  // Next-state, counters and registered-output values from the current position.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    sel_d      = sel_q;

    unique case (state_q)
      StVsync:  state_lines = VSYNC_LINES;
      StVback:  state_lines = V_BACK;
      StActive: state_lines = V_ACTIVE;
      default:  state_lines = V_FRONT;
    endcase
    byte_last = (32'(byte_cnt_q) == LineLen - 1);
    line_last = (32'(line_cnt_q) + 1 == state_lines);

    if (state_q == StIdle) begin
      if (start) begin
        state_d    = StVsync;
        byte_cnt_d = '0;
        line_cnt_d = '0;
        sel_d      = pattern_selector;
      end
    end else begin
      byte_cnt_d = byte_last ? '0 : byte_cnt_q + ByteW'(1);
      if (byte_last) begin
        if (line_last) begin
          line_cnt_d = '0;
          unique case (state_q)
            StVsync:  state_d = (V_BACK == 0) ? StActive : StVback;
            StVback:  state_d = StActive;
            StActive: state_d = StVfront;
            StVfront: begin
              if (continuous_mode) begin
                state_d = StVsync;
                sel_d   = pattern_selector;
              end else begin
                state_d = StIdle;
              end
            end
            default:  state_d = StIdle;
          endcase
        end else begin
          line_cnt_d = line_cnt_q + LineW'(1);
        end
      end
    end

    // Pixel colour; 8-bit FF components truncate to the all-ones RGB565 fields.
    x      = 8'(byte_cnt_q >> 1);
    y_bit3 = |(32'(line_cnt_q) & 32'd8);
    pix    = 16'h0000;
    unique case (sel_q)
      2'b00: begin
        unique case (x[3:2])
          2'd0:    pix = 16'hF800;
          2'd1:    pix = 16'h07E0;
          2'd2:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'b01: pix = {x[7:3], 11'h000};
      2'b10: begin
        unique case (x[1:0])
          2'd0:    pix = 16'hF800;
          2'd1:    pix = 16'h07E0;
          2'd2:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      default: pix = (x[3] ^ y_bit3 ^ fcnt_q[0]) ? 16'hFFFF : 16'h0000;
    endcase

    href_cur = (state_q == StActive) && (32'(byte_cnt_q) < 2 * H_ACTIVE);
    vsync_d  = (state_q == StVsync);
    href_d   = href_cur;
    data_d   = href_cur ? (byte_cnt_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    pvalid_d = href_cur && byte_cnt_q[0];
    pdata_d  = pvalid_d ? pix : pdata_q;
    busy_d   = (state_q != StIdle);
    rdy_d    = (state_q == StVfront) && byte_last && line_last;
    fcnt_d   = rdy_d ? fcnt_q + 8'd1 : fcnt_q;
  end

  // State and output registers; enable low freezes everything.
  always_ff @(posedge pattern_clk or negedge pattern_reset_n) begin
    if (!pattern_reset_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      sel_q      <= 2'b00;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      data_q     <= 8'h00;
      pvalid_q   <= 1'b0;
      pdata_q    <= 16'h0000;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
      fcnt_q     <= 8'h00;
    end else if (pattern_generator_enable) begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      sel_q      <= sel_d;
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      data_q     <= data_d;
      pvalid_q   <= pvalid_d;
      pdata_q    <= pdata_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign dvp.dvp_vsync   = vsync_q;
  assign dvp.dvp_href    = href_q;
  assign dvp.dvp_data    = data_q;
  assign dvp.pixel_valid = pvalid_q;
  assign dvp.pixel_data  = pdata_q;
  assign busy            = busy_q;
  assign frame_rdy       = rdy_q;
  assign frame_count     = fcnt_q;

endmodule

// File: tb/tb_dvp_pattern_generator.sv
// Bench for dvp_pattern_generator: per-cycle framing model plus a pixel scoreboard.
module tb_dvp_pattern_generator;
  localparam int HA = 4, VA = 2, HB = 2, VS = 1, VB = 1, VF = 1;
  localparam int L = 2 * HA + HB;
  localparam int F = L * (VS + VB + VA + VF);
  localparam int NPIX = HA * VA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       cont = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       busy, frame_rdy;
  logic [7:0] frame_count;

  dvp_pattern_generator_if dvp ();

  dvp_pattern_generator #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .pattern_clk             (clk),
    .pattern_reset_n         (rst_n),
    .pattern_generator_enable(enable),
    .pattern_selector        (sel),
    .continuous_mode         (cont),
    .start                   (start),
    .dvp                     (dvp),
    .busy                    (busy),
    .frame_rdy               (frame_rdy),
    .frame_count             (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference colour rules in plain arithmetic on x, y and completed-frame count.
  function automatic logic [15:0] ref_pix(int s, int x, int y, int fc);
    int r, g, b;
    r = 0; g = 0; b = 0;
    case (s)
      0: case ((x / 4) % 4) 0: r = 255; 1: g = 255; 2: b = 255; default: ; endcase
      1: r = x % 256;
      2: case (x % 4) 0: r = 255; 1: g = 255; 2: b = 255; default: ; endcase
      default: if ((((x / 8) % 2) ^ ((y / 8) % 2) ^ (fc % 2)) != 0) begin
        r = 255; g = 255; b = 255;
      end
    endcase
    return 16'(((r / 8) << 11) | ((g / 4) << 5) | (b / 8));
  endfunction

  // Framing expected from a frame position p in 0..F-1: {vsync, href, pvalid, busy, frame_rdy}.
  function automatic logic [4:0] exp_ctl(bit bz, int pos);
    int line, b, a;
    logic vs, hr, pv, rd;
    line = pos / L;
    b    = pos % L;
    a    = line - VS - VB;
    vs   = bz && (line < VS);
    hr   = bz && (a >= 0) && (a < VA) && (b < 2 * HA);
    pv   = hr && (b % 2 == 1);
    rd   = bz && (pos == F - 1);
    return {vs, hr, pv, bz, rd};
  endfunction

  logic [15:0] exp_q[$];
  int          fc_model;
  bit          rand_en;

  // Frame-position model; outputs appear one enabled clock after the position they describe.
  logic       en_s;
  bit         m_busy;
  int         m_pos;
  logic [4:0] exp_ctl_q;
  logic [7:0] exp_fc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s      <= 1'b0;
      m_busy    <= 1'b0;
      m_pos     <= 0;
      exp_ctl_q <= '0;
      exp_fc    <= '0;
    end else begin
      en_s <= enable;
      if (enable) begin
        exp_ctl_q <= exp_ctl(m_busy, m_pos);
        if (m_busy) begin
          if (m_pos == F - 1) begin
            exp_fc <= exp_fc + 8'd1;
            if (cont) m_pos <= 0;
            else m_busy <= 1'b0;
          end else begin
            m_pos <= m_pos + 1;
          end
        end else if (start) begin
          m_busy <= 1'b1;
          m_pos  <= 0;
        end
      end
    end
  end

  // Monitor: framing every cycle, pixel scoreboard on each fresh strobe.
  logic [15:0] last_pix;
  logic [15:0] e;
  logic [7:0]  prev_data;
  int          strobes;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_pix  = 16'h0;
      prev_data = 8'h0;
      strobes   = 0;
    end else begin
      check("ctl{vsync,href,pvalid,busy,rdy}",
            32'({dvp.dvp_vsync, dvp.dvp_href, dvp.pixel_valid, busy, frame_rdy}), 32'(exp_ctl_q));
      check("frame_count", 32'(frame_count), 32'(exp_fc));
      if (!exp_ctl_q[3]) check("blank_data", 32'(dvp.dvp_data), 32'(0));
      if (en_s && dvp.pixel_valid) begin
        check("pixel_queue_empty", 32'(exp_q.size() == 0), 32'(0));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pixel_data", 32'(dvp.pixel_data), 32'(e));
          check("low_byte", 32'(dvp.dvp_data), 32'(e[7:0]));
          check("high_byte", 32'(prev_data), 32'(e[15:8]));
          last_pix = e;
        end
        strobes++;
      end else begin
        check("pixel_data_hold", 32'(dvp.pixel_data), 32'(last_pix));
      end
      if (en_s && frame_rdy) begin
        check("strobes_per_frame", 32'(strobes), 32'(NPIX));
        strobes = 0;
      end
      if (en_s) prev_data = dvp.dvp_data;
    end
  end

  task automatic push_frame(int s);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) exp_q.push_back(ref_pix(s, x, y, fc_model));
  endtask

  task automatic step();
    @(negedge clk);
    enable = rand_en ? ($urandom_range(0, 5) != 0) : 1'b1;
  endtask

  task automatic wait_rdy();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (frame_rdy && en_s) seen = 1'b1;
    end
    check("frame_rdy_seen", 32'(seen), 32'(1));
  endtask

  task automatic launch(int s, bit c);
    @(negedge clk);
    sel = 2'(s); cont = c; start = 1'b1; enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic single(int s);
    launch(s, 1'b0);
    push_frame(s);
    wait_rdy();
    fc_model++;
  endtask

  task automatic cont_run(int n, int s0);
    int s;
    launch(s0, 1'b1);
    push_frame(s0);
    for (int i = 1; i < n; i++) begin
      s = (i == 1) ? s0 : int'($urandom_range(0, 3));
      sel = 2'(s);  // mid-frame change, must only affect the next frame
      wait_rdy();
      fc_model++;
      push_frame(s);
      if (i == n - 1) cont = 1'b0;
    end
    wait_rdy();
    fc_model++;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_vsync"}, 32'(dvp.dvp_vsync), 32'(0));
    check({tag, "_href"}, 32'(dvp.dvp_href), 32'(0));
    check({tag, "_data"}, 32'(dvp.dvp_data), 32'(0));
    check({tag, "_pvalid"}, 32'(dvp.pixel_valid), 32'(0));
    check({tag, "_pdata"}, 32'(dvp.pixel_data), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_rdy"}, 32'(frame_rdy), 32'(0));
    check({tag, "_fcount"}, 32'(frame_count), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rand_en  = 1'b0;
    fc_model = 0;
    enable   = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    single(2);                  // stripes: F8 00 07 E0 00 1F 00 00
    single(0);                  // bars: all red in the first 4 pixels

    // Start pulses while busy and a selector change mid-frame.
    launch(1, 1'b0);
    push_frame(1);
    sel = 2'b11;
    for (int i = 0; i < 4; i++) begin
      repeat (6) step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_rdy();
    fc_model++;
    single(3);

    cont_run(4, 3);             // checker phase flips every frame

    // Five-clock enable gap in the middle of an active line.
    launch(2, 1'b0);
    push_frame(2);
    repeat (24) step();
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_rdy();
    fc_model++;

    // Asynchronous reset in the middle of the active region.
    launch(0, 1'b0);
    push_frame(0);
    repeat (24) step();
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    fc_model = 0;
    single(2);

    rand_en = 1'b1;
    repeat (6) single(int'($urandom_range(0, 3)));
    cont_run(3, int'($urandom_range(0, 3)));
    rand_en = 1'b0;

    repeat (3) step();
    check("leftover_pixels", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
